branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  Update/resolution end of the BTB interface. Carries each IF-stage BTB prediction down IF->ID->EX, compares it with the real outcome in EX,
//  raises a redirect on mispredict and drives the BTB write port (wr_req/PC_EX/PC_Branch/isTakenBr_Ex) one cycle later.
//  Sits between the BTB, the hazard unit (stall/flush) and the EX branch comparator.
// PARAMETERS
//  INST_BYTES  4   fall-through increment added to the EX PC (PC_EX + INST_BYTES)
//  CNT_WIDTH   32  width of the statistics counters (only with BR_STATS_EN)
// PORTS
//  clk            in   1         clock; all state on posedge
//  rst            in   1         asynchronous, active-high reset
//  isTakenBr_BTB  in   1         BTB prediction for the instruction in IF
//  predictedPC    in   32        BTB target for the instruction in IF
//  bubble_IF      in   1         IF slot holds no instruction
//  stall_ID       in   1         hold IF/ID prediction register
//  flush_ID       in   1         invalidate IF/ID prediction register
//  stall_EX       in   1         hold ID/EX prediction register (EX instruction not leaving)
//  flush_EX       in   1         invalidate ID/EX prediction register
//  PC_EX          in   32        PC of the instruction in EX
//  isBranch_EX    in   1         EX instruction is a conditional branch or jal/jalr
//  isTakenBr_Ex   in   1         actual outcome in EX
//  brTarget_EX    in   32        actual target in EX
//  redirect       out  1         mispredict: fetch must restart at redirect_pc; hazard unit flushes ID/EX
//  redirect_pc    out  32        restart address
//  btb_wr_req     out  1         BTB update request (registered)
//  btb_wr_pc      out  32        PC to update (registered)
//  btb_wr_target  out  32        branch target to store (registered)
//  btb_wr_taken   out  1         taken bit to store (registered)
//  br_cnt         out  CNT_WIDTH resolved control-flow instructions (BR_STATS_EN)
//  mispred_cnt    out  CNT_WIDTH mispredicts (BR_STATS_EN)
// BEHAVIOUR
//  - Stage regs IF/ID, ID/EX each hold {valid, pred_taken, pred_target}.
//  - IF/ID load: valid = !bubble_IF, pred_taken = isTakenBr_BTB, pred_target = predictedPC.
//  - Flush beats stall on the same stage; a flush clears valid and pred_taken and sets pred_target = 0.
//  - Stall holds the stage. When ID is stalled and EX is not, a bubble (valid = 0) enters ID/EX.
//  - Resolve happens only when ID/EX.valid && !stall_EX && !flush_EX, so each instruction resolves exactly once. resolve = 0 otherwise.
//  - Mispredict, evaluated in order of the cases below:
//    a) isBranch_EX, actual taken, predicted not taken -> redirect_pc = brTarget_EX
//    b) isBranch_EX, actual not taken, predicted taken -> redirect_pc = PC_EX + INST_BYTES
//    c) isBranch_EX, both taken, pred_target != brTarget_EX -> redirect_pc = brTarget_EX
//    d) !isBranch_EX, predicted taken (alias) -> redirect_pc = PC_EX + INST_BYTES
//  - redirect is combinational in the resolve cycle; redirect = 0 and redirect_pc = 0 when there is no mispredict.
//  - PC add is 32-bit and wraps modulo 2^32 (0xFFFFFFFC + 4 = 0).
//  - BTB write: on every resolve with isBranch_EX, or in case d. Registered at the next posedge, so it is visible one cycle after resolve and is a single-cycle pulse.
//    Case d writes btb_wr_taken = 0 and btb_wr_target = 0 so the aliased entry is cleared. Otherwise btb_wr_target = brTarget_EX and btb_wr_taken = isTakenBr_Ex.
//  - Reset (also mid-operation): all stage regs invalid and zeroed; redirect = 0, redirect_pc = 0, btb_wr_* = 0, counters = 0.
//    A BTB write pending at reset is dropped.
// CONFIGURATION
//  - BR_STATS_EN defined: br_cnt increments on every resolve with isBranch_EX; mispred_cnt increments on every redirect.
//    Both counters saturate at all-ones, and both may increment in the same cycle.
//  - BR_STATS_EN undefined: counter logic is removed and br_cnt/mispred_cnt are tied to 0. Ports remain.
// STRUCTURE
//  - Package br_pkg: typedef struct packed {logic valid; logic pred_taken; logic [31:0] pred_target;} pred_info_t; localparam PC_W = 32.
//  - Sub-module pred_pipe_reg (one pred_info_t stage with stall/flush priority), instantiated twice for IF/ID and ID/EX.
// TESTING
//  1. Cold BTB: branch at PC 0x100, taken to 0x80, predicted 0 -> redirect = 1, redirect_pc = 0x80;
//     next cycle btb_wr_req = 1, btb_wr_pc = 0x100, btb_wr_target = 0x80, btb_wr_taken = 1.
//  2. Predicted taken to 0x80, actual not taken at PC 0x100 -> redirect_pc = 0x104; BTB write with taken = 0.
//  3. Correct prediction (taken, 0x80 = 0x80) -> redirect = 0, one BTB write; wrong target 0x90 vs 0x80 -> redirect_pc = 0x80.
//  4. Non-branch at 0x200 predicted taken -> redirect_pc = 0x204; BTB write with pc 0x200, taken 0, target 0.
//  5. stall_EX held 3 cycles on a mispredicting branch -> exactly one redirect pulse and one btb_wr_req pulse, on release.
//     flush_EX asserted together with stall_EX -> no redirect.
//  6. rst asserted mid-resolve -> all outputs 0 immediately, pending write dropped.
//     With BR_STATS_EN, counters preset near all-ones -> saturate, no wrap.

Source files
------------

// File: rtl/br_pkg.sv
// Shared types for the branch resolve unit: the per-stage prediction record
// that travels down IF->ID->EX next to the instruction.
package br_pkg;

    localparam int unsigned PC_W = 32;

    typedef struct packed {
        logic            valid;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } pred_info_t;

    localparam pred_info_t PredEmpty = '0;

endpackage

// File: rtl/pred_pipe_reg.sv
// One pipeline stage of prediction info. Flush beats stall; a flushed stage is
// fully zeroed so a stale target can never be compared later.
module pred_pipe_reg
    import br_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       stall_i,
    input  logic       flush_i,
    input  pred_info_t d_i,
    output pred_info_t q_o
);

    pred_info_t stage_d, stage_q;

    always_comb begin
        stage_d = d_i;
        if (flush_i) begin
            stage_d = PredEmpty;
        end else if (stall_i) begin
            stage_d = stage_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= PredEmpty;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves BTB predictions in EX, raises redirects and drives the registered
// BTB write port. Define BR_STATS_EN to build the saturating statistics counters.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int unsigned INST_BYTES = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 isTakenBr_BTB,
    input  logic [PC_W-1:0]      predictedPC,
    input  logic                 bubble_IF,
    input  logic                 stall_ID,
    input  logic                 flush_ID,
    input  logic                 stall_EX,
    input  logic                 flush_EX,
    input  logic [PC_W-1:0]      PC_EX,
    input  logic                 isBranch_EX,
    input  logic                 isTakenBr_Ex,
    input  logic [PC_W-1:0]      brTarget_EX,
    output logic                 redirect,
    output logic [PC_W-1:0]      redirect_pc,
    output logic                 btb_wr_req,
    output logic [PC_W-1:0]      btb_wr_pc,
    output logic [PC_W-1:0]      btb_wr_target,
    output logic                 btb_wr_taken,
    output logic [CNT_WIDTH-1:0] br_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    pred_info_t if_in, id_ex_in, if_id, id_ex;

    always_comb begin
        if_in.valid       = !bubble_IF;
        if_in.pred_taken  = isTakenBr_BTB;
        if_in.pred_target = predictedPC;
        // ID held while EX drains: a bubble enters EX instead of a duplicate
        id_ex_in = stall_ID ? PredEmpty : if_id;
    end

    pred_pipe_reg u_if_id (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall_ID),
        .flush_i (flush_ID),
        .d_i     (if_in),
        .q_o     (if_id)
    );

    pred_pipe_reg u_id_ex (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall_EX),
        .flush_i (flush_EX),
        .d_i     (id_ex_in),
        .q_o     (id_ex)
    );

    logic            resolve;
    logic            mispred;
    logic [PC_W-1:0] fall_pc;
    logic [PC_W-1:0] restart_pc;
    logic            wr_en;
    logic [PC_W-1:0] wr_target;
    logic            wr_taken;

    always_comb begin
        resolve    = id_ex.valid && !stall_EX && !flush_EX;
        fall_pc    = PC_EX + PC_W'(INST_BYTES);
        mispred    = 1'b0;
        restart_pc = '0;
        wr_en      = 1'b0;
        wr_target  = '0;
        wr_taken   = 1'b0;
        if (resolve) begin
            if (isBranch_EX) begin
                wr_en     = 1'b1;
                wr_target = brTarget_EX;
                wr_taken  = isTakenBr_Ex;
                if (isTakenBr_Ex && !id_ex.pred_taken) begin
                    mispred    = 1'b1;
                    restart_pc = brTarget_EX;
                end else if (!isTakenBr_Ex && id_ex.pred_taken) begin
                    mispred    = 1'b1;
                    restart_pc = fall_pc;
                end else if (isTakenBr_Ex && id_ex.pred_target != brTarget_EX) begin
                    mispred    = 1'b1;
                    restart_pc = brTarget_EX;
                end
            end else if (id_ex.pred_taken) begin
                // Aliased BTB hit on a non-branch: restart and clear the entry
                mispred    = 1'b1;
                restart_pc = fall_pc;
                wr_en      = 1'b1;
            end
        end
    end

    assign redirect    = mispred;
    assign redirect_pc = restart_pc;

    logic            btb_wr_req_d, btb_wr_req_q;
    logic [PC_W-1:0] btb_wr_pc_d, btb_wr_pc_q;
    logic [PC_W-1:0] btb_wr_target_d, btb_wr_target_q;
    logic            btb_wr_taken_d, btb_wr_taken_q;

    always_comb begin
        btb_wr_req_d    = wr_en;
        btb_wr_pc_d     = wr_en ? PC_EX : '0;
        btb_wr_target_d = wr_target;
        btb_wr_taken_d  = wr_taken;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_wr_req_q    <= 1'b0;
            btb_wr_pc_q     <= '0;
            btb_wr_target_q <= '0;
            btb_wr_taken_q  <= 1'b0;
        end else begin
            btb_wr_req_q    <= btb_wr_req_d;
            btb_wr_pc_q     <= btb_wr_pc_d;
            btb_wr_target_q <= btb_wr_target_d;
            btb_wr_taken_q  <= btb_wr_taken_d;
        end
    end

    assign btb_wr_req    = btb_wr_req_q;
    assign btb_wr_pc     = btb_wr_pc_q;
    assign btb_wr_target = btb_wr_target_q;
    assign btb_wr_taken  = btb_wr_taken_q;

`ifdef BR_STATS_EN
    logic [CNT_WIDTH-1:0] br_cnt_d, br_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_d, mispred_cnt_q;

    always_comb begin
        br_cnt_d      = br_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (resolve && isBranch_EX && br_cnt_q != '1) begin
            br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
        end
        if (mispred && mispred_cnt_q != '1) begin
            mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt_q      <= '0;
            mispred_cnt_q <= '0;
        end else begin
            br_cnt_q      <= br_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign br_cnt      = br_cnt_q;
    assign mispred_cnt = mispred_cnt_q;
`else
    assign br_cnt      = '0;
    assign mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized bench for branch_resolve_unit against a cycle-level
// behavioural model of the prediction pipeline and resolve rules.
module tb_branch_resolve_unit;

`ifdef BR_STATS_EN
    localparam int unsigned TbCw = 4;
`else
    localparam int unsigned TbCw = 32;
`endif
    localparam longint CntMax = (64'd1 << TbCw) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            isTakenBr_BTB;
    logic [31:0]     predictedPC;
    logic            bubble_IF, stall_ID, flush_ID, stall_EX, flush_EX;
    logic [31:0]     PC_EX;
    logic            isBranch_EX, isTakenBr_Ex;
    logic [31:0]     brTarget_EX;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            btb_wr_req;
    logic [31:0]     btb_wr_pc, btb_wr_target;
    logic            btb_wr_taken;
    logic [TbCw-1:0] br_cnt, mispred_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .INST_BYTES (4),
        .CNT_WIDTH  (TbCw)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .isTakenBr_BTB (isTakenBr_BTB),
        .predictedPC   (predictedPC),
        .bubble_IF     (bubble_IF),
        .stall_ID      (stall_ID),
        .flush_ID      (flush_ID),
        .stall_EX      (stall_EX),
        .flush_EX      (flush_EX),
        .PC_EX         (PC_EX),
        .isBranch_EX   (isBranch_EX),
        .isTakenBr_Ex  (isTakenBr_Ex),
        .brTarget_EX   (brTarget_EX),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .btb_wr_req    (btb_wr_req),
        .btb_wr_pc     (btb_wr_pc),
        .btb_wr_target (btb_wr_target),
        .btb_wr_taken  (btb_wr_taken),
        .br_cnt        (br_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    // Model: prediction slots in ID and EX, last BTB write, counters
    typedef struct {bit v; bit t; bit [31:0] tg;} slot_t;
    slot_t  m_id, m_ex;
    bit        m_wr_req, m_wr_tk;
    bit [31:0] m_wr_pc, m_wr_tg;
    longint    m_br, m_mis;
    bit        e_res, e_redir, e_wr, e_wtk;
    bit [31:0] e_rpc, e_wtg;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_id = '{0, 0, 0};
        m_ex = '{0, 0, 0};
        m_wr_req = 0; m_wr_tk = 0; m_wr_pc = 0; m_wr_tg = 0;
        m_br = 0; m_mis = 0;
    endtask

    task automatic model_comb();
        bit [31:0] fall;
        fall = PC_EX + 32'd4;
        e_res = m_ex.v && !stall_EX && !flush_EX;
        e_redir = 0; e_rpc = 0; e_wr = 0; e_wtg = 0; e_wtk = 0;
        if (e_res && isBranch_EX) begin
            e_wr = 1; e_wtg = brTarget_EX; e_wtk = isTakenBr_Ex;
            if (isTakenBr_Ex != m_ex.t) begin
                e_redir = 1;
                e_rpc = isTakenBr_Ex ? brTarget_EX : fall;
            end else if (isTakenBr_Ex && m_ex.tg != brTarget_EX) begin
                e_redir = 1;
                e_rpc = brTarget_EX;
            end
        end else if (e_res && m_ex.t) begin
            e_redir = 1; e_rpc = fall; e_wr = 1;
        end
    endtask

    task automatic settle_check();
        #1;
        model_comb();
        chk("redirect", redirect, e_redir);
        chk("redirect_pc", redirect_pc, e_rpc);
        chk("btb_wr_req", btb_wr_req, m_wr_req);
        chk("btb_wr_pc", btb_wr_pc, m_wr_pc);
        chk("btb_wr_target", btb_wr_target, m_wr_tg);
        chk("btb_wr_taken", btb_wr_taken, m_wr_tk);
        chk("br_cnt", br_cnt, m_br);
        chk("mispred_cnt", mispred_cnt, m_mis);
    endtask

    task automatic advance();
        slot_t n_id, n_ex;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            model_comb();
            if (flush_ID) n_id = '{0, 0, 0};
            else if (stall_ID) n_id = m_id;
            else n_id = '{!bubble_IF, isTakenBr_BTB, predictedPC};
            if (flush_EX) n_ex = '{0, 0, 0};
            else if (stall_EX) n_ex = m_ex;
            else if (stall_ID) n_ex = '{0, 0, 0};
            else n_ex = m_id;
            m_id = n_id;
            m_ex = n_ex;
            m_wr_req = e_wr;
            m_wr_pc = e_wr ? PC_EX : 32'd0;
            m_wr_tg = e_wtg;
            m_wr_tk = e_wtk;
`ifdef BR_STATS_EN
            if (e_res && isBranch_EX && m_br < CntMax) m_br++;
            if (e_redir && m_mis < CntMax) m_mis++;
`endif
        end
        @(negedge clk);
    endtask

    task automatic set_if(input bit bub, input bit tk, input bit [31:0] tg);
        bubble_IF = bub; isTakenBr_BTB = tk; predictedPC = tg;
    endtask

    task automatic set_ex(input bit [31:0] pc, input bit isb, input bit tk, input bit [31:0] tg);
        PC_EX = pc; isBranch_EX = isb; isTakenBr_Ex = tk; brTarget_EX = tg;
    endtask

    // Fetch one predicted instruction and move it into EX; IF then idles
    task automatic issue(input bit pt, input bit [31:0] ptg);
        set_if(0, pt, ptg); set_ex(0, 0, 0, 0);
        settle_check(); advance();
        set_if(1, 0, 0);
        settle_check(); advance();
    endtask

    initial begin
        rst = 1'b1;
        stall_ID = 0; flush_ID = 0; stall_EX = 0; flush_EX = 0;
        set_if(1, 0, 0); set_ex(0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        settle_check();
        rst = 1'b0;
        settle_check();

        // Cold BTB: taken branch predicted not taken
        issue(0, 0);
        set_ex(32'h100, 1, 1, 32'h80);
        settle_check();
        chk("t1_redirect", redirect, 1);
        chk("t1_rpc", redirect_pc, 32'h80);
        advance();
        set_ex(0, 0, 0, 0);
        settle_check();
        chk("t1_wr_req", btb_wr_req, 1);
        chk("t1_wr_pc", btb_wr_pc, 32'h100);
        chk("t1_wr_target", btb_wr_target, 32'h80);
        chk("t1_wr_taken", btb_wr_taken, 1);
        advance();

        // Predicted taken, actually not taken
        issue(1, 32'h80);
        set_ex(32'h100, 1, 0, 32'h80);
        settle_check();
        chk("t2_rpc", redirect_pc, 32'h104);
        advance();
        set_ex(0, 0, 0, 0);
        settle_check();
        chk("t2_wr_req", btb_wr_req, 1);
        chk("t2_wr_taken", btb_wr_taken, 0);
        advance();

        // Correct prediction followed by a wrong-target prediction
        set_if(0, 1, 32'h80); settle_check(); advance();
        set_if(0, 1, 32'h90); settle_check(); advance();
        set_if(1, 0, 0);
        set_ex(32'h100, 1, 1, 32'h80);
        settle_check();
        chk("t3_ok_redirect", redirect, 0);
        advance();
        set_ex(32'h108, 1, 1, 32'h80);
        settle_check();
        chk("t3_tgt_redirect", redirect, 1);
        chk("t3_tgt_rpc", redirect_pc, 32'h80);
        chk("t3_ok_wr_req", btb_wr_req, 1);
        advance();
        set_ex(0, 0, 0, 0);
        settle_check();
        chk("t3_tgt_wr_pc", btb_wr_pc, 32'h108);
        advance();

        // Aliased non-branch predicted taken
        issue(1, 32'h340);
        set_ex(32'h200, 0, 0, 32'h55);
        settle_check();
        chk("t4_rpc", redirect_pc, 32'h204);
        advance();
        set_ex(0, 0, 0, 0);
        settle_check();
        chk("t4_wr_req", btb_wr_req, 1);
        chk("t4_wr_pc", btb_wr_pc, 32'h200);
        chk("t4_wr_taken", btb_wr_taken, 0);
        chk("t4_wr_target", btb_wr_target, 0);
        advance();

        // Fall-through wraps at the top of the address space
        issue(1, 32'h80);
        set_ex(32'hFFFF_FFFC, 1, 0, 32'h80);
        settle_check();
        chk("wrap_rpc", redirect_pc, 0);
        chk("wrap_redirect", redirect, 1);
        advance();

        // EX stalled three cycles: a single redirect and write on release
        issue(0, 0);
        set_ex(32'h100, 1, 1, 32'h80);
        stall_EX = 1; stall_ID = 1;
        for (int i = 0; i < 3; i++) begin
            settle_check();
            chk("t5_stall_redirect", redirect, 0);
            advance();
            settle_check();
            chk("t5_stall_wr_req", btb_wr_req, 0);
        end
        stall_EX = 0; stall_ID = 0;
        settle_check();
        chk("t5_release_redirect", redirect, 1);
        advance();
        set_ex(0, 0, 0, 0);
        settle_check();
        chk("t5_after_redirect", redirect, 0);
        chk("t5_wr_req", btb_wr_req, 1);
        advance();
        settle_check();
        chk("t5_wr_pulse_end", btb_wr_req, 0);
        advance();

        // Flush together with stall kills the resolve
        issue(0, 0);
        set_ex(32'h100, 1, 1, 32'h80);
        stall_EX = 1; flush_EX = 1;
        settle_check();
        chk("t5_flush_redirect", redirect, 0);
        advance();
        stall_EX = 0; flush_EX = 0;
        settle_check();
        chk("t5_flush_redirect2", redirect, 0);
        chk("t5_flush_wr_req", btb_wr_req, 0);
        advance();

        // Reset in the middle of a mispredicting resolve
        issue(0, 0);
        set_ex(32'h100, 1, 1, 32'h80);
        settle_check();
        chk("t6_pre_redirect", redirect, 1);
        rst = 1'b1;
        model_reset();
        settle_check();
        chk("t6_rst_redirect", redirect, 0);
        chk("t6_rst_rpc", redirect_pc, 0);
        advance();
        rst = 1'b0;
        settle_check();
        chk("t6_dropped_wr", btb_wr_req, 0);
        advance();

        // Randomized traffic against the model (drives counters to saturation)
        for (int n = 0; n < 600; n++) begin
            bit [31:0] tgs [4];
            tgs[0] = 32'h80; tgs[1] = 32'h90; tgs[2] = 32'h1000; tgs[3] = 32'hFFFF_FFF0;
            set_if($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, tgs[$urandom_range(0, 3)]);
            stall_ID = $urandom_range(0, 7) == 0;
            flush_ID = $urandom_range(0, 9) == 0;
            stall_EX = $urandom_range(0, 7) == 0;
            flush_EX = $urandom_range(0, 9) == 0;
            if (stall_EX) stall_ID = 1;
            set_ex(($urandom_range(0, 5) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                   tgs[$urandom_range(0, 3)]);
            settle_check();
            advance();
        end
        stall_ID = 0; flush_ID = 0; stall_EX = 0; flush_EX = 0;
        set_if(1, 0, 0); set_ex(0, 0, 0, 0);
        settle_check();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
